// File: rtl/input_pkg.sv
// Shared types and default parameter values for the button input bank.
// The channel state enum is only consumed when BUTTON_AUTO_REPEAT_EN is defined.
package input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD_DELAY,
        HELD_REPEAT
    } chan_state_t;

    localparam int DEF_N_CH         = 4;
    localparam int DEF_SAMPLE_DIV   = 1000000;
    localparam int DEF_STABLE_CNT   = 2;
    localparam int DEF_REPEAT_DELAY = 15;
    localparam int DEF_REPEAT_RATE  = 5;

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, tick-sampled debounce, edge pulses and,
// when BUTTON_AUTO_REPEAT_EN is defined, an auto-repeat FSM.
module button_channel
    import input_pkg::*;
#(
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int AW = $clog2(STABLE_CNT + 1);

    if (STABLE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("button_channel: STABLE_CNT, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [1:0]    sync;
    logic [AW-1:0] agree;
    logic          disagree;
    logic          change;

    // change marks the tick on which the debounced level flips
    always_comb begin
        disagree = tick && (sync[1] != pressed);
        change   = disagree && (agree == AW'(STABLE_CNT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= '0;
            agree         <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync          <= {sync[0], raw};
            press_pulse   <= change && !pressed;
            release_pulse <= change && pressed;
            if (change) begin
                pressed <= !pressed;
                agree   <= '0;
            end else if (disagree) begin
                agree <= agree + 1'b1;
            end else if (tick) begin
                agree <= '0;
            end
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    chan_state_t   state;
    logic [RW-1:0] rcnt;

    // In the held states a change is always a release, which wins over a repeat
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rcnt         <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (change) begin
                        state <= HELD_DELAY;
                        rcnt  <= '0;
                    end
                end
                HELD_DELAY: begin
                    if (change) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                            state        <= HELD_REPEAT;
                            repeat_pulse <= 1'b1;
                            rcnt         <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                HELD_REPEAT: begin
                    if (change) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (rcnt == RW'(REPEAT_RATE - 1)) begin
                            repeat_pulse <= 1'b1;
                            rcnt         <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_input_bank.sv
// Bank of N_CH debounced buttons sharing one sample-tick prescaler.
// Auto-repeat is included only when BUTTON_AUTO_REPEAT_EN is defined.
module button_input_bank
    import input_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int PW = $clog2(SAMPLE_DIV);

    if (N_CH < 1 || SAMPLE_DIV < 2) begin : g_bad_param
        $error("button_input_bank: N_CH must be >= 1 and SAMPLE_DIV >= 2");
    end

    logic [PW-1:0] presc;
    logic          tick;

    always_comb tick = (presc == PW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .raw          (raw_in[i]),
            .tick         (tick),
            .pressed      (pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule
